// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide functional unit with a private CDB lane.
// One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
// Optional feature macro: PROCYON_MULDIV_EARLY_OUT_EN (trivial ops skip the iterations).

package procyon_pkg;
  typedef logic [6:0]  procyon_opcode_t;
  typedef logic [31:0] procyon_addr_t;
  typedef logic [31:0] procyon_data_t;
  typedef logic [5:0]  procyon_tag_t;
endpackage

module muldiv_unit
  import procyon_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_flush,
  input  logic                  i_fu_valid,
  input  procyon_opcode_t       i_fu_opcode,
  input  procyon_addr_t         i_fu_iaddr,
  input  procyon_data_t         i_fu_insn,
  input  logic [DATA_WIDTH-1:0] i_fu_src_a,
  input  logic [DATA_WIDTH-1:0] i_fu_src_b,
  input  procyon_tag_t          i_fu_tag,
  output logic                  o_fu_stall,
  output logic                  o_cdb_en,
  output logic                  o_cdb_redirect,
  output logic [DATA_WIDTH-1:0] o_cdb_data,
  output procyon_addr_t         o_cdb_addr,
  output procyon_tag_t          o_cdb_tag
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;        // {hi, lo}: product, or {remainder, quotient}
  logic [DW-1:0]   divisor_q, divisor_d; // multiplicand or divisor magnitude
  logic [2:0]      funct3_q, funct3_d;
  logic            neg_q, neg_d;         // negate the selected result at the end
  procyon_tag_t    tag_q, tag_d;
  procyon_addr_t   addr_q, addr_d;

  // Opcode is redundant with funct3 for this unit; only insn[14:12] matters.
  logic unused_inputs;
  assign unused_inputs = ^{i_fu_opcode, i_fu_insn[31:15], i_fu_insn[11:0]};

  // Issue-side decode: operand signedness, magnitudes and final sign
  logic [2:0]    funct3;
  logic          a_signed, b_signed, sign_a, sign_b, b_zero, accept, neg_in;
  logic [DW-1:0] mag_a, mag_b;

  assign funct3   = i_fu_insn[14:12];
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sign_a   = a_signed & i_fu_src_a[DW-1];
  assign sign_b   = b_signed & i_fu_src_b[DW-1];
  assign mag_a    = sign_a ? -i_fu_src_a : i_fu_src_a;
  assign mag_b    = sign_b ? -i_fu_src_b : i_fu_src_b;
  assign b_zero   = (i_fu_src_b == '0);
  assign accept   = i_fu_valid & (state_q == IDLE) & ~i_flush;
  // Divide-by-zero quotient must stay all-ones, so it is never negated.
  assign neg_in   = ~funct3[2] ? (sign_a ^ sign_b) :
                     funct3[1] ? sign_a : ((sign_a ^ sign_b) & ~b_zero);

`ifdef PROCYON_MULDIV_EARLY_OUT_EN
  // Trivial ops: load the final magnitudes directly and skip the iterations.
  logic            a_zero, ovf, early_out;
  logic [2*DW-1:0] early_acc;
  assign a_zero    = (i_fu_src_a == '0);
  assign ovf       = funct3[2] & ~funct3[0] &
                     (i_fu_src_a == {1'b1, {(DW-1){1'b0}}}) & (&i_fu_src_b);
  assign early_out = funct3[2] ? (b_zero | ovf) : (a_zero | b_zero);
  assign early_acc = ~funct3[2] ? '0 :
                      b_zero    ? {mag_a, {DW{1'b1}}} : {{DW{1'b0}}, mag_a};
`endif

  // One iteration of each algorithm from the current accumulator
  logic [DW:0]     mul_sum, div_trial;
  logic [2*DW-1:0] mul_next, div_next;
  assign mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
  assign mul_next  = {mul_sum, acc_q[DW-1:1]};
  assign div_trial = acc_q[2*DW-1:DW-1] - {1'b0, divisor_q};
  assign div_next  = div_trial[DW] ? {acc_q[2*DW-2:0], 1'b0}
                                   : {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};

  // Next-state and datapath update; flush always wins and returns to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    funct3_d  = funct3_q;
    neg_d     = neg_q;
    tag_d     = tag_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = BUSY;
          cnt_d     = '0;
          acc_d     = {{DW{1'b0}}, mag_a};
          divisor_d = mag_b;
          funct3_d  = funct3;
          neg_d     = neg_in;
          tag_d     = i_fu_tag;
          addr_d    = i_fu_iaddr;
`ifdef PROCYON_MULDIV_EARLY_OUT_EN
          if (early_out) begin
            state_d = DONE;
            acc_d   = early_acc;
          end
`endif
        end
      end
      BUSY: begin
        acc_d = funct3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers carry no reset; they are only consumed in DONE
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    divisor_q <= divisor_d;
    funct3_q  <= funct3_d;
    neg_q     <= neg_d;
    tag_q     <= tag_d;
    addr_q    <= addr_d;
  end

  // Result selection and sign correction from registered state only
  logic [2*DW-1:0] mul_full;
  logic [DW-1:0]   mul_res, div_sel, div_res;
  assign mul_full = neg_q ? -acc_q : acc_q;
  assign mul_res  = (funct3_q == 3'b000) ? mul_full[DW-1:0] : mul_full[2*DW-1:DW];
  assign div_sel  = funct3_q[1] ? acc_q[2*DW-1:DW] : acc_q[DW-1:0];
  assign div_res  = neg_q ? -div_sel : div_sel;

  assign o_fu_stall     = (state_q != IDLE);
  assign o_cdb_en       = (state_q == DONE) & ~i_flush & ~n_rst;
  assign o_cdb_redirect = 1'b0;
  assign o_cdb_data     = funct3_q[2] ? div_res : mul_res;
  assign o_cdb_tag      = tag_q;
  assign o_cdb_addr     = addr_q;

endmodule
